// File: rtl/ffe_mac_sequencer_pkg.sv
// ffe_mac_sequencer_pkg: shared state encodings, default sizing and a clog2 helper
// for the FFE MAC sequencer slice.  Rev 1.0
`default_nettype none

package ffe_mac_sequencer_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return (result < 1) ? 1 : result;
   endfunction

   localparam int DEF_NUM_TAPS  = 4;
   localparam int DEF_ADDR_W    = clog2(DEF_NUM_TAPS);
   localparam int DEF_OVR_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_MAC   = 3'd2,
      ST_STORE = 3'd3,
      ST_COEF  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ffe_mac_sequencer_tap_counter.sv
// ffe_tap_counter: load-to-zero / increment tap index with terminal count at NUM_TAPS-1.
// Rev 1.0
`default_nettype none

module ffe_tap_counter #(
   parameter int NUM_TAPS = 4,
   parameter int ADDR_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   output logic [ADDR_W-1:0] cnt,
   output logic              tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + ADDR_W'(1);
      end
   end

   assign tc = (cnt == ADDR_W'(NUM_TAPS - 1));

endmodule

`default_nettype wire

// File: rtl/ffe_mac_sequencer.sv
// ffe_mac_sequencer: sequences the shared FFE MAC per sample, arbitrates coefficient
// writes, buffers one early sample and counts overruns.  Rev 1.0
`default_nettype none

module ffe_mac_sequencer
   import ffe_mac_sequencer_pkg::*;
#(
   parameter int NUM_TAPS  = DEF_NUM_TAPS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int OVR_CNT_W = DEF_OVR_CNT_W
) (
   input  logic                 ffe_clk,
   input  logic                 rst,
   input  logic                 sample_vld,
   input  logic                 coef_wr_req,
   input  logic                 ovr_clr,
   output logic                 shift_en,
   output logic [ADDR_W-1:0]    rd_addr,
   output logic                 acc_clr,
   output logic                 acc_en,
   output logic                 out_str,
   output logic                 coef_wr_gnt,
   output logic                 busy,
   output logic                 ovr_flag,
   output logic [OVR_CNT_W-1:0] ovr_cnt
);

   state_t      state;
   state_t      next_state;
   logic        pending;
   logic        next_pending;
   logic        drop;
   logic        tap_tc;
   logic        tap_load;
   logic        tap_inc;

   // A sample arriving in STORE/COEF is never lost: it either starts the next
   // SHIFT directly or becomes the pending sample behind the one being consumed.
   always_comb begin
      next_state   = state;
      next_pending = pending;
      case (state)
         ST_IDLE: begin
            if (sample_vld) begin
               next_state = ST_SHIFT;
            end else if (coef_wr_req) begin
               next_state = ST_COEF;
            end
         end
         ST_SHIFT: begin
            next_state   = ST_MAC;
            next_pending = pending | sample_vld;
         end
         ST_MAC: begin
            if (tap_tc) begin
               next_state = ST_STORE;
            end
            next_pending = pending | sample_vld;
         end
         ST_STORE, ST_COEF: begin
            next_state   = (pending | sample_vld) ? ST_SHIFT : ST_IDLE;
            next_pending = pending & sample_vld;
         end
         default: begin
            next_state   = ST_IDLE;
            next_pending = 1'b0;
         end
      endcase
   end

   assign drop     = sample_vld & pending & (next_state != ST_SHIFT);
   assign tap_load = (next_state == ST_SHIFT);
   assign tap_inc  = (state == ST_MAC) & ~tap_tc;

   ffe_tap_counter #(
      .NUM_TAPS (NUM_TAPS),
      .ADDR_W   (ADDR_W)
   ) u_tap_counter (
      .clk   (ffe_clk),
      .rst_n (rst),
      .load  (tap_load),
      .inc   (tap_inc),
      .cnt   (rd_addr),
      .tc    (tap_tc)
   );

   // Outputs are registered from the next-state decode so they line up with the state.
   always_ff @(posedge ffe_clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         pending     <= 1'b0;
         shift_en    <= 1'b0;
         acc_clr     <= 1'b0;
         acc_en      <= 1'b0;
         out_str     <= 1'b0;
         coef_wr_gnt <= 1'b0;
         busy        <= 1'b0;
         ovr_flag    <= 1'b0;
         ovr_cnt     <= '0;
      end else begin
         state       <= next_state;
         pending     <= next_pending;
         shift_en    <= (next_state == ST_SHIFT);
         acc_en      <= (next_state == ST_MAC);
         acc_clr     <= (next_state == ST_MAC) && (state == ST_SHIFT);
         out_str     <= (next_state == ST_STORE);
         coef_wr_gnt <= (next_state == ST_COEF);
         busy        <= (next_state != ST_IDLE);
         if (drop) begin
            ovr_flag <= 1'b1;
            if (ovr_clr) begin
               ovr_cnt <= OVR_CNT_W'(1);
            end else if (ovr_cnt != {OVR_CNT_W{1'b1}}) begin
               ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
            end
         end else if (ovr_clr) begin
            ovr_flag <= 1'b0;
            ovr_cnt  <= '0;
         end
      end
   end

   a_no_pending_in_idle : assert property (
      @(posedge ffe_clk) disable iff (!rst) (state == ST_IDLE) |-> !pending
   );

endmodule

`default_nettype wire
